// File: rtl/pulser_pkg.sv
// Shared types for the pulse sequencer: FSM states, data width, table entry layout.
// Pure declarations; no timing or backpressure of its own.
package pulser_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        WAIT_RUN,
        WAIT_END,
        NEXT,
        DONE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] delay;
        logic [DATA_W-1:0] width;
    } entry_t;

endpackage

// File: rtl/pulse_sequencer_if.sv
// Host, table-write and pulse_counter signals of the sequencer; slave is the sequencer side.
// No logic; host writes are dropped by the sequencer while it is busy.
interface pulse_sequencer_if #(
    parameter int AW    = 4,
    parameter int RPT_W = 16
);
    import pulser_pkg::*;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_delay;
    logic [DATA_W-1:0] wr_width;
    logic [AW:0]       num_entries;
    logic [RPT_W-1:0]  repeats;
    logic              ext_mode;
    logic              start;
    logic              abort;
    logic              trig_in;
    logic [DATA_W-1:0] pc_delay;
    logic [DATA_W-1:0] pc_width;
    logic              pc_trigger;
    logic              pc_running;
    logic              busy;
    logic              done;
    logic [AW-1:0]     entry_idx;
    logic [RPT_W-1:0]  pass_cnt;

    modport master (
        output wr_en, wr_addr, wr_delay, wr_width, num_entries, repeats,
               ext_mode, start, abort, trig_in, pc_running,
        input  pc_delay, pc_width, pc_trigger, busy, done, entry_idx, pass_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_delay, wr_width, num_entries, repeats,
               ext_mode, start, abort, trig_in, pc_running,
        output pc_delay, pc_width, pc_trigger, busy, done, entry_idx, pass_cnt
    );

endinterface

// File: rtl/seq_table.sv
// (delay, width) register file: synchronous write, combinational read, no reset.
// Zero-latency read; write always accepted when wr_en is high.
module seq_table
    import pulser_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  entry_t        wr_dat,
    input  logic [AW-1:0] rd_addr,
    output entry_t        rd_dat
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/pulse_sequencer.sv
// Steps a pulse_counter through a table of (delay, width) entries; start to first trigger is one cycle.
// Waits on pc_running (and trig_in in ext_mode) between entries; table writes dropped while busy.
module pulse_sequencer
    import pulser_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int RPT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    pulse_sequencer_if.slave bus
);

    state_t            state_q, state_d;
    logic [AW:0]       ne_q, ne_d, ne_clamped, idx_inc;
    logic [RPT_W-1:0]  rpt_q, rpt_d, pass_q, pass_d, pass_inc;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] dly_q, wid_q;
    logic              last_entry;
    entry_t            rd_dat;
    entry_t            wr_dat;

    assign wr_dat = '{delay: bus.wr_delay, width: bus.wr_width};

    seq_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
        .clk     (clk),
        .wr_en   (bus.wr_en && (state_q == IDLE)),
        .wr_addr (bus.wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (idx_d),
        .rd_dat  (rd_dat)
    );

    assign ne_clamped = (bus.num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_entries;
    assign idx_inc    = {1'b0, idx_q} + (AW+1)'(1);
    assign last_entry = (idx_inc == ne_q);
    // Saturation only matters for endless runs; bounded runs stop at repeats.
    assign pass_inc   = (&pass_q) ? pass_q : pass_q + RPT_W'(1);

    always_comb begin
        state_d = state_q;
        ne_d    = ne_q;
        rpt_d   = rpt_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    ne_d   = ne_clamped;
                    rpt_d  = bus.repeats;
                    idx_d  = '0;
                    pass_d = '0;
                    if (ne_clamped == '0) state_d = DONE;
                    else                  state_d = bus.ext_mode ? ARM : FIRE;
                end
            end
            ARM: begin
                if (bus.abort)        state_d = IDLE;
                else if (bus.trig_in) state_d = FIRE;
            end
            FIRE: state_d = bus.abort ? IDLE : WAIT_RUN;
            WAIT_RUN: begin
                if (bus.abort)           state_d = DRAIN;
                else if (bus.pc_running) state_d = WAIT_END;
            end
            WAIT_END: begin
                if (bus.abort)            state_d = DRAIN;
                else if (!bus.pc_running) state_d = NEXT;
            end
            NEXT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = last_entry ? '0 : idx_inc[AW-1:0];
                    pass_d  = last_entry ? pass_inc : pass_q;
                    state_d = bus.ext_mode ? ARM : FIRE;
                    if (last_entry && (rpt_q != '0) && (pass_inc == rpt_q)) state_d = DONE;
                end
            end
            DONE:  state_d = IDLE;
            DRAIN: if (!bus.pc_running) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ne_q    <= '0;
            rpt_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
        end else begin
            state_q <= state_d;
            ne_q    <= ne_d;
            rpt_q   <= rpt_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            // Counter parameters change only on FIRE entry so they stay stable across a pulse.
            if ((state_d == FIRE) && (state_q != FIRE)) begin
                dly_q <= rd_dat.delay;
                wid_q <= rd_dat.width;
            end
        end
    end

    assign bus.pc_delay   = dly_q;
    assign bus.pc_width   = wid_q;
    assign bus.pc_trigger = (state_q == FIRE) && !bus.abort;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.entry_idx  = idx_q;
    assign bus.pass_cnt   = pass_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with a behavioural pulse_counter model attached.
module tb_pulse_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    pulse_sequencer_if #(.AW(4), .RPT_W(16)) bus ();

    pulse_sequencer #(.DEPTH(16), .AW(4), .RPT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // pulse_counter model: running rises one cycle after trigger is sampled, lasts delay+width+1 cycles
    logic        m_pend;
    logic        m_running;
    logic [32:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend    <= 1'b0;
            m_running <= 1'b0;
            m_cnt     <= '0;
        end else begin
            m_pend <= bus.pc_trigger;
            if (m_pend) begin
                m_running <= 1'b1;
                m_cnt     <= {1'b0, bus.pc_delay} + {1'b0, bus.pc_width};
            end else if (m_running) begin
                if (m_cnt == 0) m_running <= 1'b0;
                else            m_cnt <= m_cnt - 1;
            end
        end
    end

    assign bus.pc_running = m_running;

    int exp_d [3];
    int exp_w [3];

    task automatic wr_entry(input int a, input int d, input int w);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'(a);
        bus.wr_delay = 32'(d);
        bus.wr_width = 32'(w);
        @(negedge clk);
        bus.wr_en    = 1'b0;
    endtask

    // Pulses start, then observes one cycle per iteration until busy drops or the budget runs out.
    task automatic run_seq(input int n, input int budget,
                           output int ntrig, output int ndone, output int perr, output int nwrap,
                           output int trig2_cyc, output int done_cyc, output int iters,
                           output int first_d, output int first_w, output bit tmo);
        int prev_idx;
        ntrig = 0; ndone = 0; perr = 0; nwrap = 0;
        trig2_cyc = -1; done_cyc = -1; iters = -1; first_d = -1; first_w = -1;
        tmo = 1'b1;
        prev_idx = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (!bus.busy) begin
                iters = c;
                tmo   = 1'b0;
                break;
            end
            if (bus.pc_trigger) begin
                ntrig++;
                if (ntrig == 1) begin
                    first_d = int'(bus.pc_delay);
                    first_w = int'(bus.pc_width);
                end
                if (ntrig == 2) trig2_cyc = c;
            end
            if (bus.done) begin
                ndone++;
                done_cyc = c;
            end
            if (bus.pc_running && ntrig > 0 && n > 0) begin
                if (int'(bus.pc_delay) != exp_d[(ntrig-1) % n] ||
                    int'(bus.pc_width) != exp_w[(ntrig-1) % n]) perr++;
            end
            if (prev_idx == n-1 && int'(bus.entry_idx) == 0 && n > 1) nwrap++;
            prev_idx = int'(bus.entry_idx);
        end
    endtask

    task automatic test_reset();
        #1;
        vecs++; if (bus.pc_delay !== 32'd0)  begin errs++; $display("FAIL reset_pc_delay got %0d exp 0", bus.pc_delay); end
        vecs++; if (bus.pc_width !== 32'd0)  begin errs++; $display("FAIL reset_pc_width got %0d exp 0", bus.pc_width); end
        vecs++; if (bus.pc_trigger !== 1'b0) begin errs++; $display("FAIL reset_pc_trigger got %b exp 0", bus.pc_trigger); end
        vecs++; if (bus.busy !== 1'b0)       begin errs++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        vecs++; if (bus.done !== 1'b0)       begin errs++; $display("FAIL reset_done got %b exp 0", bus.done); end
        vecs++; if (bus.entry_idx !== 4'd0)  begin errs++; $display("FAIL reset_entry_idx got %0d exp 0", bus.entry_idx); end
        vecs++; if (bus.pass_cnt !== 16'd0)  begin errs++; $display("FAIL reset_pass_cnt got %0d exp 0", bus.pass_cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        int nt, nd, pe, nw, t2, dc, it, fd, fw;
        bit to;
        bus.repeats = 16'd1; bus.ext_mode = 1'b0; bus.num_entries = 5'd3;
        run_seq(3, 200, nt, nd, pe, nw, t2, dc, it, fd, fw, to);
        vecs++; if (to)       begin errs++; $display("FAIL pass1_timeout got busy exp idle"); end
        vecs++; if (nt != 3)  begin errs++; $display("FAIL pass1_triggers got %0d exp 3", nt); end
        vecs++; if (fd != 2 || fw != 3) begin errs++; $display("FAIL pass1_first_entry got (%0d,%0d) exp (2,3)", fd, fw); end
        vecs++; if (t2 != 10) begin errs++; $display("FAIL pass1_gap got cycle %0d exp 10", t2); end
        vecs++; if (pe != 0)  begin errs++; $display("FAIL pass1_params got %0d bad cycles exp 0", pe); end
        vecs++; if (nd != 1)  begin errs++; $display("FAIL pass1_done_count got %0d exp 1", nd); end
        vecs++; if (dc != 26) begin errs++; $display("FAIL pass1_done_cycle got %0d exp 26", dc); end
        vecs++; if (it != 27) begin errs++; $display("FAIL pass1_busy_drop got %0d exp 27", it); end
        vecs++; if (bus.pass_cnt !== 16'd1) begin errs++; $display("FAIL pass1_pass_cnt got %0d exp 1", bus.pass_cnt); end
    endtask

    task automatic test_repeat_two();
        int nt, nd, pe, nw, t2, dc, it, fd, fw;
        bit to;
        bus.repeats = 16'd2; bus.ext_mode = 1'b0; bus.num_entries = 5'd3;
        run_seq(3, 300, nt, nd, pe, nw, t2, dc, it, fd, fw, to);
        vecs++; if (to)      begin errs++; $display("FAIL rpt2_timeout got busy exp idle"); end
        vecs++; if (nt != 6) begin errs++; $display("FAIL rpt2_triggers got %0d exp 6", nt); end
        vecs++; if (pe != 0) begin errs++; $display("FAIL rpt2_params got %0d bad cycles exp 0", pe); end
        vecs++; if (nw != 2) begin errs++; $display("FAIL rpt2_wraps got %0d exp 2", nw); end
        vecs++; if (nd != 1) begin errs++; $display("FAIL rpt2_done_count got %0d exp 1", nd); end
        vecs++; if (bus.pass_cnt !== 16'd2) begin errs++; $display("FAIL rpt2_pass_cnt got %0d exp 2", bus.pass_cnt); end
    endtask

    task automatic test_ext_mode();
        int nt = 0, nd = 0, t1 = -1, t2 = -1, d2 = -1;
        bit to = 1'b1;
        wr_entry(0, 40, 5);
        wr_entry(1, 3, 2);
        bus.repeats = 16'd1; bus.ext_mode = 1'b1; bus.num_entries = 5'd2;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (!bus.busy) begin to = 1'b0; break; end
            if (bus.pc_trigger) begin
                nt++;
                if (nt == 1) t1 = c;
                if (nt == 2) begin t2 = c; d2 = int'(bus.pc_delay); end
            end
            if (bus.done) nd++;
            bus.trig_in = (c == 10 || c == 40 || c == 41 || c == 80);
        end
        bus.trig_in = 1'b0;
        vecs++; if (to)      begin errs++; $display("FAIL ext_timeout got busy exp idle"); end
        vecs++; if (nt != 2) begin errs++; $display("FAIL ext_triggers got %0d exp 2", nt); end
        vecs++; if (t1 != 11) begin errs++; $display("FAIL ext_first_fire got %0d exp 11", t1); end
        vecs++; if (t2 != 81) begin errs++; $display("FAIL ext_second_fire got %0d exp 81", t2); end
        vecs++; if (d2 != 3) begin errs++; $display("FAIL ext_second_delay got %0d exp 3", d2); end
        vecs++; if (nd != 1) begin errs++; $display("FAIL ext_done_count got %0d exp 1", nd); end
    endtask

    task automatic test_abort();
        int nt = 0, nd = 0;
        bit to = 1'b1, seen = 1'b0;
        bus.repeats = 16'd0; bus.ext_mode = 1'b0; bus.num_entries = 5'd2;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.pc_running) begin seen = 1'b1; break; end
        end
        vecs++; if (!seen) begin errs++; $display("FAIL abort_running got 0 exp 1"); end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vecs++; if (bus.busy !== 1'b1 || bus.pc_running !== 1'b1)
            begin errs++; $display("FAIL abort_drain got busy=%b running=%b exp 1 1", bus.busy, bus.pc_running); end
        for (int c = 0; c < 100; c++) begin
            if (!bus.busy) begin to = 1'b0; break; end
            if (bus.pc_trigger) nt++;
            if (bus.done) nd++;
            @(negedge clk);
        end
        vecs++; if (to)      begin errs++; $display("FAIL abort_timeout got busy exp idle"); end
        vecs++; if (nt != 0) begin errs++; $display("FAIL abort_triggers got %0d exp 0", nt); end
        vecs++; if (nd != 0) begin errs++; $display("FAIL abort_done got %0d exp 0", nd); end
        vecs++; if (bus.pc_running !== 1'b0) begin errs++; $display("FAIL abort_idle_early got running=%b exp 0", bus.pc_running); end
    endtask

    task automatic test_zero_entries();
        int nt, nd, pe, nw, t2, dc, it, fd, fw;
        bit to;
        bus.repeats = 16'd1; bus.ext_mode = 1'b0; bus.num_entries = 5'd0;
        run_seq(0, 20, nt, nd, pe, nw, t2, dc, it, fd, fw, to);
        vecs++; if (to)      begin errs++; $display("FAIL zero_timeout got busy exp idle"); end
        vecs++; if (dc != 0) begin errs++; $display("FAIL zero_done_cycle got %0d exp 0", dc); end
        vecs++; if (it != 1) begin errs++; $display("FAIL zero_busy_drop got %0d exp 1", it); end
        vecs++; if (nt != 0) begin errs++; $display("FAIL zero_triggers got %0d exp 0", nt); end
    endtask

    task automatic test_async_reset_and_locked_write();
        int nt, nd, pe, nw, t2, dc, it, fd, fw;
        bit to = 1'b1;
        wr_entry(0, 2, 3);
        exp_d[0] = 2; exp_w[0] = 3;
        bus.repeats = 16'd1; bus.ext_mode = 1'b0; bus.num_entries = 5'd1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vecs++; if (bus.pc_trigger !== 1'b1) begin errs++; $display("FAIL arst_in_fire got %b exp 1", bus.pc_trigger); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (bus.pc_trigger !== 1'b0 || bus.busy !== 1'b0 || bus.pc_delay !== 32'd0 ||
                    bus.pc_width !== 32'd0 || bus.entry_idx !== 4'd0 || bus.pass_cnt !== 16'd0)
            begin errs++; $display("FAIL arst_outputs got trig=%b busy=%b d=%0d w=%0d exp all 0",
                                   bus.pc_trigger, bus.busy, bus.pc_delay, bus.pc_width); end
        @(negedge clk);
        rst = 1'b0;
        // Write attempted during FIRE must be dropped.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_delay = 32'd99;
        bus.wr_width = 32'd99;
        @(negedge clk);
        bus.wr_en = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!bus.busy) begin to = 1'b0; break; end
            @(negedge clk);
        end
        vecs++; if (to) begin errs++; $display("FAIL lockwr_timeout got busy exp idle"); end
        run_seq(1, 100, nt, nd, pe, nw, t2, dc, it, fd, fw, to);
        vecs++; if (fd != 2 || fw != 3) begin errs++; $display("FAIL lockwr_table got (%0d,%0d) exp (2,3)", fd, fw); end
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_delay = '0; bus.wr_width = '0;
        bus.num_entries = '0; bus.repeats = '0; bus.ext_mode = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.trig_in = 1'b0;
        exp_d = '{2, 0, 5};
        exp_w = '{3, 1, 0};
        test_reset();
        wr_entry(0, 2, 3);
        wr_entry(1, 0, 1);
        wr_entry(2, 5, 0);
        test_single_pass();
        test_repeat_two();
        test_ext_mode();
        test_abort();
        test_zero_entries();
        test_async_reset_and_locked_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
